hazard_ctrl_mc: RTL

//  Pipeline hazard controller for the 5-stage MIPS core; drives the stall/clear inputs of the F/D, D/E, E/M registers.

---
 rtl/hazard_ctrl_mc_if.sv | 32 +++
 rtl/hazard_ctrl_mc.sv | 100 ++++++++++
 2 files changed

// File: rtl/hazard_ctrl_mc_if.sv
// Hazard-controller bus: pipeline-side source/destination info in,
// stall/flush/forward controls out.
interface hazard_ctrl_mc_if;
   logic [4:0] RsD, RtD, RsE, RtE;
   logic [4:0] WriteRegE, WriteRegM, WriteRegW;
   logic       RegWriteE, RegWriteM, RegWriteW;
   logic       MemtoRegE, MemtoRegM;
   logic       BranchD, MulE;
   logic       StallF, StallD, StallE;
   logic       FlushE, FlushM;
   logic       ForwardAD, ForwardBD;
   logic [1:0] ForwardAE, ForwardBE;
   logic       MulBusy;

   // Pipeline datapath side: supplies register info, consumes controls.
   modport master (
      output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
             RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
             BranchD, MulE,
      input  StallF, StallD, StallE, FlushE, FlushM,
             ForwardAD, ForwardBD, ForwardAE, ForwardBE, MulBusy
   );

   // Hazard controller side.
   modport slave (
      input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
             RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
             BranchD, MulE,
      output StallF, StallD, StallE, FlushE, FlushM,
             ForwardAD, ForwardBD, ForwardAE, ForwardBE, MulBusy
   );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage MIPS core: load-use and branch-compare
// stalls, D/E forwarding selects, and a small FSM that holds a multi-cycle
// MUL in E for MUL_LAT cycles while bubbles are injected into M.
module hazard_ctrl_mc #(
   parameter int MUL_LAT = 4,
   parameter int CW      = 4
) (
   input  logic              clk,
   input  logic              reset,
   hazard_ctrl_mc_if.slave   hz
);

   if (MUL_LAT < 2 || MUL_LAT > 16) begin : g_bad_mul_lat
      $error("hazard_ctrl_mc: MUL_LAT must be in 2..16");
   end
   if ((2 ** CW) <= (MUL_LAT - 2)) begin : g_bad_cw
      $error("hazard_ctrl_mc: CW too narrow to hold MUL_LAT-2");
   end

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mulstall;
   logic          lwstall, brstall;

   // E-stage forward select: M beats W; $0 never forwards.
   function automatic logic [1:0] fwd_e(input logic [4:0] src,
                                        input logic [4:0] wr_m, input logic rw_m,
                                        input logic [4:0] wr_w, input logic rw_w);
      if (src != 5'd0 && src == wr_m && rw_m)      return 2'b10;
      else if (src != 5'd0 && src == wr_w && rw_w) return 2'b01;
      else                                         return 2'b00;
   endfunction

   // Forwarding selects for the D-stage comparator and the E-stage ALU.
   always_comb begin
      hz.ForwardAE = fwd_e(hz.RsE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW);
      hz.ForwardBE = fwd_e(hz.RtE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW);
      hz.ForwardAD = (hz.RsD != 5'd0) && (hz.RsD == hz.WriteRegM) && hz.RegWriteM;
      hz.ForwardBD = (hz.RtD != 5'd0) && (hz.RtD == hz.WriteRegM) && hz.RegWriteM;
   end

   // Load-use and branch-compare hazards; $0 is not excluded here on purpose.
   always_comb begin
      lwstall = hz.MemtoRegE && ((hz.RtE == hz.RsD) || (hz.RtE == hz.RtD));
      brstall = hz.BranchD &&
                ((hz.RegWriteE && ((hz.WriteRegE == hz.RsD) || (hz.WriteRegE == hz.RtD))) ||
                 (hz.MemtoRegM && ((hz.WriteRegM == hz.RsD) || (hz.WriteRegM == hz.RtD))));
   end

   // MUL FSM state and down-counter registers.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // MUL FSM next state: stall MUL_LAT-1 cycles, then one drain cycle that ignores MulE.
   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mulstall = 1'b0;
      case (state_q)
         IDLE: begin
            if (hz.MulE) begin
               mulstall = 1'b1;
               state_d  = BUSY;
               cnt_d    = CW'(MUL_LAT - 2);
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               mulstall = 1'b1;
               cnt_d    = cnt_q - CW'(1);
            end else begin
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Pipeline register controls; the MUL held in E is never flushed.
   always_comb begin
      hz.StallF  = lwstall | brstall | mulstall;
      hz.StallD  = lwstall | brstall | mulstall;
      hz.StallE  = mulstall;
      hz.FlushM  = mulstall;
      hz.FlushE  = (lwstall | brstall) & ~mulstall;
      hz.MulBusy = (state_q == BUSY);
   end

endmodule
